// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter: requester IDs and small ID helpers.
package ibex_pkg;

   typedef enum logic {
      ArbIdPrefetch  = 1'b0,
      ArbIdSecondary = 1'b1
   } instr_arb_id_e;

   function automatic instr_arb_id_e arb_other_id(input instr_arb_id_e id);
      return (id == ArbIdPrefetch) ? ArbIdSecondary : ArbIdPrefetch;
   endfunction

   function automatic logic [1:0] arb_onehot(input instr_arb_id_e id);
      return (id == ArbIdSecondary) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// In-order queue of requester IDs for granted-but-unanswered memory transactions.
module ibex_instr_arb_id_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_push,
   input  instr_arb_id_e   i_id,
   input  logic            i_pop,
   output instr_arb_id_e   o_head,
   output logic            o_full,
   output logic            o_empty,
   output logic [CntW-1:0] o_count
);

   instr_arb_id_e   r_mem [Depth];
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;

   // Pointers wrap modulo Depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            r_mem[i] <= ArbIdPrefetch;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_id;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (i_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CntW'(Depth));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Shares one instruction-memory port between the prefetch buffer (id 0) and a secondary fetcher (id 1).
module ibex_instr_bus_arbiter
   import ibex_pkg::*;
#(
   parameter int unsigned NumOutstanding = 2,
   parameter bit          RoundRobin     = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       req_i,
   input  logic [1:0][31:0] addr_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic             instr_req_o,
   input  logic             instr_gnt_i,
   output logic [31:0]      instr_addr_o,
   input  logic             instr_rvalid_i,
   input  logic [31:0]      instr_rdata_i,
   input  logic             instr_err_i,
   output logic             busy_o,
   output logic             spurious_rvalid_o
);

   localparam int unsigned CntW = $clog2(NumOutstanding + 1);

   logic            r_locked;
   instr_arb_id_e   r_lock_id;
   instr_arb_id_e   r_rr_ptr;

   instr_arb_id_e   w_winner;
   instr_arb_id_e   w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_grant;
   logic            w_pop;
   logic            w_stall;
   logic [CntW-1:0] w_count;

   always_comb begin
      w_winner = r_rr_ptr;
      if (r_locked) begin
         w_winner = r_lock_id;
      end else if (RoundRobin) begin
         w_winner = req_i[r_rr_ptr] ? r_rr_ptr : arb_other_id(r_rr_ptr);
      end else begin
         w_winner = req_i[0] ? ArbIdPrefetch : ArbIdSecondary;
      end
   end

   // A lock can only exist while not full (count cannot grow without a grant).
   assign instr_req_o  = (r_locked | (|req_i)) & ~w_full;
   assign w_grant      = instr_req_o & instr_gnt_i;
   assign w_stall      = instr_req_o & ~instr_gnt_i;
   assign instr_addr_o = instr_req_o ? addr_i[w_winner] : '0;
   assign gnt_o        = w_grant ? arb_onehot(w_winner) : '0;

   assign w_pop             = instr_rvalid_i & ~w_empty;
   assign rvalid_o          = w_pop ? arb_onehot(w_head) : '0;
   assign rdata_o           = instr_rdata_i;
   assign err_o             = instr_err_i;
   assign spurious_rvalid_o = instr_rvalid_i & w_empty;
   assign busy_o            = (w_count != '0) | instr_req_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_locked  <= 1'b0;
         r_lock_id <= ArbIdPrefetch;
         r_rr_ptr  <= ArbIdPrefetch;
      end else begin
         r_locked <= w_stall;
         if (w_stall) begin
            r_lock_id <= w_winner;
         end
         if (w_grant) begin
            r_rr_ptr <= arb_other_id(w_winner);
         end
      end
   end

   ibex_instr_arb_id_fifo #(
      .Depth (NumOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_grant),
      .i_id    (w_winner),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Self-checking bench for ibex_instr_bus_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_ibex_instr_bus_arbiter;

   localparam int unsigned NOUT = 2;
   localparam bit          RR   = 1'b1;

   logic             clk;
   logic             rst_ni;
   logic [1:0]       req_i;
   logic [1:0][31:0] addr_i;
   logic [1:0]       gnt_o;
   logic [1:0]       rvalid_o;
   logic [31:0]      rdata_o;
   logic             err_o;
   logic             instr_req_o;
   logic             instr_gnt_i;
   logic [31:0]      instr_addr_o;
   logic             instr_rvalid_i;
   logic [31:0]      instr_rdata_i;
   logic             instr_err_i;
   logic             busy_o;
   logic             spurious_rvalid_o;

   ibex_instr_bus_arbiter #(
      .NumOutstanding (NOUT),
      .RoundRobin     (RR)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .req_i             (req_i),
      .addr_i            (addr_i),
      .gnt_o             (gnt_o),
      .rvalid_o          (rvalid_o),
      .rdata_o           (rdata_o),
      .err_o             (err_o),
      .instr_req_o       (instr_req_o),
      .instr_gnt_i       (instr_gnt_i),
      .instr_addr_o      (instr_addr_o),
      .instr_rvalid_i    (instr_rvalid_i),
      .instr_rdata_i     (instr_rdata_i),
      .instr_err_i       (instr_err_i),
      .busy_o            (busy_o),
      .spurious_rvalid_o (spurious_rvalid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: ordered list of outstanding requester ids plus lock/preference bits.
   int   q[$];
   bit   m_locked;
   int   m_lock_id;
   int   m_pref;
   int   e_win;
   bit   e_req;
   bit   e_grant;
   logic [1:0]  e_gnt;
   logic [1:0]  e_rv;
   bit   e_sp;
   bit   e_busy;
   logic [31:0] e_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_eval();
      bit full;
      full = (q.size() == NOUT);
      if (m_locked)      e_win = m_lock_id;
      else if (RR)       e_win = req_i[m_pref] ? m_pref : 1 - m_pref;
      else               e_win = req_i[0] ? 0 : 1;
      e_req   = (m_locked || req_i != 2'b00) && !full;
      e_grant = e_req && instr_gnt_i;
      e_gnt   = e_grant ? (2'b01 << e_win) : 2'b00;
      e_rv    = (instr_rvalid_i && q.size() > 0) ? (2'b01 << q[0]) : 2'b00;
      e_sp    = instr_rvalid_i && q.size() == 0;
      e_busy  = (q.size() != 0) || e_req;
      e_addr  = addr_i[e_win];
   endtask

   task automatic model_update();
      if (instr_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (e_grant) begin
         q.push_back(e_win);
         m_pref = 1 - e_win;
      end
      m_locked = e_req && !instr_gnt_i;
      if (m_locked) m_lock_id = e_win;
   endtask

   task automatic drive(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                        input logic g, input logic rv, input logic [31:0] rd, input logic er);
      req_i          = r;
      addr_i[0]      = a0;
      addr_i[1]      = a1;
      instr_gnt_i    = g;
      instr_rvalid_i = rv;
      instr_rdata_i  = rd;
      instr_err_i    = er;
      #3;
      model_eval();
      chk("gnt_o",    32'(gnt_o),             32'(e_gnt));
      chk("req_o",    32'(instr_req_o),       32'(e_req));
      chk("rvalid_o", 32'(rvalid_o),          32'(e_rv));
      chk("spurious", 32'(spurious_rvalid_o), 32'(e_sp));
      chk("busy_o",   32'(busy_o),            32'(e_busy));
      chk("rdata_o",  rdata_o,                rd);
      chk("err_o",    32'(err_o),             32'(er));
      if (e_req) chk("addr_o", instr_addr_o, e_addr);
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                       input logic g, input logic rv);
      drive(r, a0, a1, g, rv, 32'h0, 1'b0);
      advance();
   endtask

   task automatic do_reset();
      rst_ni         = 1'b0;
      req_i          = '0;
      addr_i         = '0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
      @(posedge clk);
      #1;
      rst_ni    = 1'b1;
      q.delete();
      m_locked  = 1'b0;
      m_lock_id = 0;
      m_pref    = 0;
   endtask

   logic [1:0]  pend;
   logic [31:0] pa0, pa1;
   logic [1:0]  gexp;

   initial begin
      rst_ni = 1'b0;
      req_i = '0; addr_i = '0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
      @(posedge clk);
      #1;

      // 1: idle after reset, single fetch from requester 0 with one stall cycle
      do_reset();
      drive(2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 0);
      chk("t1_idle_req",  32'(instr_req_o), 32'h0);
      chk("t1_idle_busy", 32'(busy_o), 32'h0);
      advance();
      step(2'b01, 32'h100, 32'h0, 0, 0);
      drive(2'b01, 32'h100, 32'h0, 1, 0, 32'h0, 0);
      chk("t1_addr", instr_addr_o, 32'h100);
      chk("t1_gnt",  32'(gnt_o), 32'h1);
      advance();
      step(2'b00, 32'h0, 32'h0, 0, 0);
      drive(2'b00, 32'h0, 32'h0, 0, 1, 32'hCAFE_0100, 1'b1);
      chk("t1_rvalid", 32'(rvalid_o), 32'h1);
      advance();

      // 2: both requesting, memory always grants: alternation and in-order returns
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 1, k > 0, 32'(k), 0);
         chk("t2_gnt_alt", 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) chk("t2_rv_alt", 32'(rvalid_o), (k % 2 == 1) ? 32'h1 : 32'h2);
         advance();
      end
      step(2'b00, 0, 0, 0, 1);

      // 3: requester 1 locked through stalls, requester 0 cannot preempt
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(2'b10, 32'h0, 32'h200, 0, 0, 32'h0, 0);
         chk("t3_lock_addr", instr_addr_o, 32'h200);
         advance();
      end
      drive(2'b11, 32'h300, 32'h200, 0, 0, 32'h0, 0);
      chk("t3_no_preempt", instr_addr_o, 32'h200);
      advance();
      drive(2'b11, 32'h300, 32'h200, 1, 0, 32'h0, 0);
      chk("t3_gnt1", 32'(gnt_o), 32'h2);
      advance();
      drive(2'b01, 32'h300, 32'h0, 1, 0, 32'h0, 0);
      chk("t3_next_id0", 32'(gnt_o), 32'h1);
      advance();
      step(2'b00, 0, 0, 0, 1);
      step(2'b00, 0, 0, 0, 1);

      // 4: full at two outstanding, no same-cycle bypass, push+pop at count 1
      do_reset();
      step(2'b01, 32'h400, 0, 1, 0);
      step(2'b01, 32'h404, 0, 1, 0);
      drive(2'b01, 32'h408, 0, 1, 0, 32'h0, 0);
      chk("t4_full_req", 32'(instr_req_o), 32'h0);
      advance();
      drive(2'b01, 32'h408, 0, 1, 1, 32'h0, 0);
      chk("t4_no_bypass", 32'(instr_req_o), 32'h0);
      advance();
      drive(2'b01, 32'h408, 0, 1, 1, 32'h0, 0);
      chk("t4_req_again", 32'(instr_req_o), 32'h1);
      advance();
      step(2'b00, 0, 0, 0, 1);
      drive(2'b00, 0, 0, 0, 0, 32'h0, 0);
      chk("t4_drained", 32'(busy_o), 32'h0);
      advance();

      // 5: spurious response on an empty queue
      do_reset();
      drive(2'b00, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      chk("t5_spur", 32'(spurious_rvalid_o), 32'h1);
      chk("t5_rv",   32'(rvalid_o), 32'h0);
      advance();
      drive(2'b00, 0, 0, 0, 0, 32'h0, 0);
      chk("t5_spur_gone", 32'(spurious_rvalid_o), 32'h0);
      chk("t5_busy",      32'(busy_o), 32'h0);
      advance();

      // 6: reset with two outstanding, then a late response
      step(2'b10, 0, 32'h600, 1, 0);
      step(2'b01, 32'h604, 0, 1, 0);
      do_reset();
      drive(2'b00, 0, 0, 0, 0, 32'h0, 0);
      chk("t6_req",  32'(instr_req_o), 32'h0);
      chk("t6_busy", 32'(busy_o), 32'h0);
      advance();
      drive(2'b00, 0, 0, 0, 1, 32'h0, 0);
      chk("t6_late_spur", 32'(spurious_rvalid_o), 32'h1);
      advance();

      // Random traffic: requesters hold until granted; memory grants/responds at random
      do_reset();
      pend = 2'b00;
      pa0  = '0;
      pa1  = '0;
      for (int c = 0; c < 600; c++) begin
         if (!pend[0] && $urandom_range(2) == 0) begin pend[0] = 1'b1; pa0 = $urandom & 32'hFFFF_FFFC; end
         if (!pend[1] && $urandom_range(2) == 0) begin pend[1] = 1'b1; pa1 = $urandom & 32'hFFFF_FFFC; end
         drive(pend, pa0, pa1, 1'($urandom_range(1)),
               (q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0),
               $urandom, 1'($urandom_range(1)));
         gexp = e_gnt;
         advance();
         pend = pend & ~gexp;
      end
      for (int c = 0; c < 8 && (q.size() > 0 || pend != 2'b00); c++) begin
         drive(pend, pa0, pa1, 1'b1, q.size() > 0, $urandom, 1'b0);
         gexp = e_gnt;
         advance();
         pend = pend & ~gexp;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
